// File: rtl/commit_trace_tx_if.sv
// Commit trace bundle: retirement capture bus from the core plus the outgoing trace word stream.
// Latency: none, wires only.
// Backpressure: tx_ready_i from the stream sink; the capture side has no backpressure (drops instead).
interface commit_trace_tx_if #(
  parameter int XLEN = 32
);
  logic            update_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] instr_i;
  logic [4:0]      reg_addr_i;
  logic [XLEN-1:0] reg_data_i;
  logic            reg_we_i;
  logic            mem_read_en_i;
  logic            mem_write_en_i;
  logic [XLEN-1:0] mem_read_addr_i;
  logic [XLEN-1:0] mem_write_addr_i;
  logic [XLEN-1:0] mem_write_data_i;
  logic [1:0]      store_size_i;
  logic [31:0]     tx_data_o;
  logic            tx_valid_o;
  logic            tx_last_o;
  logic            tx_ready_i;
  logic            overflow_o;
  logic [15:0]     drop_count_o;
  logic            busy_o;

  // Core / stream-sink side.
  modport master (
    output update_i, pc_i, instr_i, reg_addr_i, reg_data_i, reg_we_i,
           mem_read_en_i, mem_write_en_i, mem_read_addr_i, mem_write_addr_i,
           mem_write_data_i, store_size_i, tx_ready_i,
    input  tx_data_o, tx_valid_o, tx_last_o, overflow_o, drop_count_o, busy_o
  );

  // Trace transmitter side.
  modport slave (
    input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i, reg_we_i,
           mem_read_en_i, mem_write_en_i, mem_read_addr_i, mem_write_addr_i,
           mem_write_data_i, store_size_i, tx_ready_i,
    output tx_data_o, tx_valid_o, tx_last_o, overflow_o, drop_count_o, busy_o
  );
endinterface

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: classifies retire events, queues them, serializes each as a 32-bit word packet.
// Latency: update_i in cycle N reaches tx as HDR in cycle N+2 (FIFO empty, serializer idle).
// Backpressure: tx_ready_i stalls the serializer with data held; a full FIFO drops new events and counts them.
module commit_trace_tx #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  commit_trace_tx_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] KIND_PLAIN = 2'd0;
  localparam logic [1:0] KIND_REGWR = 2'd1;
  localparam logic [1:0] KIND_LOAD  = 2'd2;
  localparam logic [1:0] KIND_STORE = 2'd3;

  // One queued record; w3/w4 are the kind-dependent trailing words.
  typedef struct packed {
    logic [7:0]  seq;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] w3;
    logic [31:0] w4;
  } rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [2:0] nwords(input logic [1:0] k);
    case (k)
      KIND_STORE, KIND_LOAD: return 3'd5;
      KIND_REGWR:            return 3'd4;
      default:               return 3'd3;
    endcase
  endfunction

  rec_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    seq;
  logic          overflow;
  logic [15:0]   drop_count;

  rec_t          cap, cur, cur_n;
  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [2:0]    cur_nw;
  logic          push_req, push, pop, drop, full, hs, last_word;
  logic [31:0]   hdr;

  // Build the record for the current event: classify and mask store data.
  always_comb begin
    cap       = '0;
    cap.seq   = seq;
    cap.pc    = pc_i_32();
    cap.instr = bus.instr_i[31:0];
    if (bus.mem_write_en_i) begin
      cap.kind = KIND_STORE;
      cap.size = bus.store_size_i;
      cap.w3   = bus.mem_write_addr_i[31:0];
      case (bus.store_size_i)
        2'b00:   cap.w4 = {24'b0, bus.mem_write_data_i[7:0]};
        2'b01:   cap.w4 = {16'b0, bus.mem_write_data_i[15:0]};
        default: cap.w4 = bus.mem_write_data_i[31:0];
      endcase
    end else if (bus.mem_read_en_i && bus.reg_addr_i != 5'd0) begin
      cap.kind = KIND_LOAD;
      cap.rd   = bus.reg_addr_i;
      cap.w3   = bus.reg_data_i[31:0];
      cap.w4   = bus.mem_read_addr_i[31:0];
    end else if (!bus.mem_read_en_i && bus.reg_we_i && bus.reg_addr_i != 5'd0) begin
      cap.kind = KIND_REGWR;
      cap.rd   = bus.reg_addr_i;
      cap.w3   = bus.reg_data_i[31:0];
    end else begin
      cap.kind = KIND_PLAIN;
    end
  end

  function automatic logic [31:0] pc_i_32();
    return bus.pc_i[31:0];
  endfunction

  // Handshake bookkeeping; a pop on the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    full      = (count == FULL_CNT);
    cur_nw    = nwords(cur.kind);
    last_word = (state == SEND) && (idx == cur_nw - 3'd1);
    hs        = (state == SEND) && bus.tx_ready_i;
    pop       = (count != '0) && ((state == IDLE) || (hs && last_word));
    push_req  = bus.update_i && (bus.pc_i != '0);
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  // Record storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sequence number advances for every non-zero-pc event, dropped or not, so drops show as gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_req) seq <= seq + 8'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cur   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cur   <= cur_n;
    end
  end

  // Serializer next state: load straight from the FIFO on the last handshake so packets abut.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cur_n   = cur;
    if (pop) begin
      state_n = SEND;
      idx_n   = '0;
      cur_n   = mem[rd_ptr];
    end else if (hs && last_word) begin
      state_n = IDLE;
      idx_n   = '0;
    end else if (hs) begin
      idx_n = idx + 3'd1;
    end
  end

  // Serializer outputs: word mux driven only by registered state, so it holds while stalled.
  always_comb begin
    hdr            = {8'hA5, cur.seq, 1'b0, cur.kind, cur.rd, cur.size, cur_nw, 3'b000};
    bus.tx_valid_o = (state == SEND);
    bus.tx_last_o  = last_word;
    bus.tx_data_o  = '0;
    if (state == SEND) begin
      case (idx)
        3'd0:    bus.tx_data_o = hdr;
        3'd1:    bus.tx_data_o = cur.pc;
        3'd2:    bus.tx_data_o = cur.instr;
        3'd3:    bus.tx_data_o = cur.w3;
        3'd4:    bus.tx_data_o = cur.w4;
        default: bus.tx_data_o = '0;
      endcase
    end
    bus.busy_o       = (count != '0) || (state == SEND);
    bus.overflow_o   = overflow;
    bus.drop_count_o = drop_count;
  end
endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: latency, packet formats, filtering, stall, overflow, reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every wait on the DUT is bounded; expiry counts as an error.
module tb_commit_trace_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  commit_trace_tx_if #(.XLEN(32)) bus ();

  commit_trace_tx #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rx_w [8];
  int          rx_n;
  bit          rx_ok;

  task automatic do_reset();
    rst = 1'b1;
    bus.update_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic we, input logic mr, input logic mw,
                        input logic [31:0] raddr, input logic [31:0] waddr, input logic [31:0] wdata,
                        input logic [1:0] sz);
    bus.update_i = 1'b1;
    bus.pc_i = pc;
    bus.instr_i = instr;
    bus.reg_addr_i = rd;
    bus.reg_data_i = rdata;
    bus.reg_we_i = we;
    bus.mem_read_en_i = mr;
    bus.mem_write_en_i = mw;
    bus.mem_read_addr_i = raddr;
    bus.mem_write_addr_i = waddr;
    bus.mem_write_data_i = wdata;
    bus.store_size_i = sz;
    @(posedge clk); #1;
    bus.update_i = 1'b0;
  endtask

  // Accept one packet with ready high; the final word is consumed before returning.
  task automatic recv_pkt();
    int cyc = 0;
    rx_n = 0;
    rx_ok = 1'b0;
    bus.tx_ready_i = 1'b1;
    while (cyc < 40 && !rx_ok) begin
      if (bus.tx_valid_o) begin
        if (rx_n < 8) rx_w[rx_n] = bus.tx_data_o;
        rx_n++;
        if (bus.tx_last_o) rx_ok = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.tx_ready_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int cyc = 0;
    ok = 1'b0;
    while (cyc < 20 && !ok) begin
      if (bus.tx_valid_o) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.tx_valid_o, bus.tx_last_o, bus.overflow_o, bus.busy_o} !== 4'b0 ||
        bus.tx_data_o !== 32'h0 || bus.drop_count_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b ovf=%b busy=%b data=%h drops=%h, expected all 0",
               bus.tx_valid_o, bus.tx_last_o, bus.overflow_o, bus.busy_o, bus.tx_data_o, bus.drop_count_o);
    end
  endtask

  task automatic test_regwr();
    logic [31:0] exp [4];
    exp[0] = 32'hA5002120; exp[1] = 32'h80000004; exp[2] = 32'h00500093; exp[3] = 32'h00000005;
    do_reset();
    bus.tx_ready_i = 1'b1;
    commit(32'h80000004, 32'h00500093, 5'd1, 32'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    checks++;
    if (bus.tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL regwr_n1_valid: got %b, expected 0", bus.tx_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 32'hA5002120) begin
      errors++;
      $display("FAIL regwr_n2_hdr: valid=%b data=%h, expected 1 a5002120", bus.tx_valid_o, bus.tx_data_o);
    end
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 4) begin
      errors++;
      $display("FAIL regwr_len: ok=%b words=%0d, expected 1 4", rx_ok, rx_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL regwr_word%0d: got %h, expected %h", i, rx_w[i], exp[i]);
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    commit(32'h80000010, 32'h00F10023, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80002000, 32'h12345678, 2'b00);
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 5 || rx_w[0] !== 32'hA5006028 || rx_w[1] !== 32'h80000010 ||
        rx_w[2] !== 32'h00F10023 || rx_w[3] !== 32'h80002000 || rx_w[4] !== 32'h00000078) begin
      errors++;
      $display("FAIL store_sb: n=%0d %h %h %h %h %h, expected 5 a5006028 80000010 00f10023 80002000 00000078",
               rx_n, rx_w[0], rx_w[1], rx_w[2], rx_w[3], rx_w[4]);
    end
    commit(32'h80000014, 32'h00F11023, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80002000, 32'h12345678, 2'b01);
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 5 || rx_w[0] !== 32'hA5016068 || rx_w[4] !== 32'h00005678) begin
      errors++;
      $display("FAIL store_sh: n=%0d hdr=%h data=%h, expected 5 a5016068 00005678", rx_n, rx_w[0], rx_w[4]);
    end
  endtask

  task automatic test_load_plain();
    do_reset();
    commit(32'h80000020, 32'h00012183, 5'd3, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h80003004, 32'h0, 32'h0, 2'b00);
    commit(32'h80000024, 32'h00012003, 5'd0, 32'h1111, 1'b1, 1'b1, 1'b0, 32'h80003008, 32'h0, 32'h0, 2'b00);
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 5 || rx_w[0] !== 32'hA5004328 || rx_w[3] !== 32'hCAFEF00D || rx_w[4] !== 32'h80003004) begin
      errors++;
      $display("FAIL load_pkt: n=%0d hdr=%h w3=%h w4=%h, expected 5 a5004328 cafef00d 80003004",
               rx_n, rx_w[0], rx_w[3], rx_w[4]);
    end
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 3 || rx_w[0] !== 32'hA5010018 || rx_w[1] !== 32'h80000024) begin
      errors++;
      $display("FAIL plain_pkt: n=%0d hdr=%h pc=%h, expected 3 a5010018 80000024", rx_n, rx_w[0], rx_w[1]);
    end
  endtask

  task automatic test_pc_zero();
    do_reset();
    commit(32'h80000030, 32'h00700113, 5'd2, 32'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    commit(32'h00000000, 32'h00000013, 5'd5, 32'd1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0, 2'b10);
    commit(32'h80000034, 32'h00900193, 5'd3, 32'd9, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    recv_pkt();
    checks++;
    if (!rx_ok || rx_w[0] !== 32'hA5002220 || rx_w[3] !== 32'd7) begin
      errors++;
      $display("FAIL pc0_first: hdr=%h data=%h, expected a5002220 00000007", rx_w[0], rx_w[3]);
    end
    recv_pkt();
    checks++;
    if (!rx_ok || rx_w[0] !== 32'hA5012320 || rx_w[1] !== 32'h80000034) begin
      errors++;
      $display("FAIL pc0_second: hdr=%h pc=%h, expected a5012320 80000034", rx_w[0], rx_w[1]);
    end
    checks++;
    if (bus.tx_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.drop_count_o !== 16'h0) begin
      errors++;
      $display("FAIL pc0_no_third: valid=%b busy=%b drops=%0d, expected 0 0 0",
               bus.tx_valid_o, bus.busy_o, bus.drop_count_o);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stable;
    do_reset();
    commit(32'h80000100, 32'h00A00113, 5'd2, 32'd10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_wait_valid: got timeout, expected valid");
    end
    bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready_i = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 32'h80000100 || bus.tx_last_o !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall_hold: got unstable PC word (last data=%h), expected 80000100 held", bus.tx_data_o);
    end
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 3 || rx_w[0] !== 32'h80000100 || rx_w[1] !== 32'h00A00113 || rx_w[2] !== 32'd10) begin
      errors++;
      $display("FAIL stall_resume: n=%0d %h %h %h, expected 3 80000100 00a00113 0000000a",
               rx_n, rx_w[0], rx_w[1], rx_w[2]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_hdr;
    logic [4:0]  rd;
    logic [7:0]  sq;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rd = 5'(i + 1);
      commit(32'h80001000 + 32'(4 * i), 32'h00100093, rd, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0,
             32'h0, 32'h0, 32'h0, 2'b00);
    end
    checks++;
    if (bus.drop_count_o !== 16'd2 || bus.overflow_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_status: drops=%0d ovf=%b busy=%b, expected 2 1 1",
               bus.drop_count_o, bus.overflow_o, bus.busy_o);
    end
    for (int p = 0; p < 5; p++) begin
      rd = 5'(p + 1);
      sq = 8'(p);
      exp_hdr = {8'hA5, sq, 3'b001, rd, 2'b00, 3'd4, 3'b000};
      recv_pkt();
      checks++;
      if (!rx_ok || rx_n !== 4 || rx_w[0] !== exp_hdr || rx_w[1] !== 32'h80001000 + 32'(4 * p) ||
          rx_w[3] !== 32'h100 + 32'(p)) begin
        errors++;
        $display("FAIL ovf_pkt%0d: n=%0d hdr=%h pc=%h data=%h, expected 4 %h %h %h", p, rx_n, rx_w[0],
                 rx_w[1], rx_w[3], exp_hdr, 32'h80001000 + 32'(4 * p), 32'h100 + 32'(p));
      end
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain: busy=%b valid=%b, expected 0 0", bus.busy_o, bus.tx_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    commit(32'h80000200, 32'h00012183, 5'd3, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h80003000, 32'h0, 32'h0, 2'b00);
    wait_valid(ok);
    bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!ok || bus.tx_data_o !== 32'h80000200 || bus.tx_last_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_word2: ok=%b data=%h last=%b, expected 1 80000200 0", ok, bus.tx_data_o, bus.tx_last_o);
    end
    rst = 1'b1;
    bus.tx_ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.tx_valid_o, bus.tx_last_o, bus.overflow_o, bus.busy_o} !== 4'b0 ||
        bus.tx_data_o !== 32'h0 || bus.drop_count_o !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b last=%b ovf=%b busy=%b data=%h, expected all 0",
               bus.tx_valid_o, bus.tx_last_o, bus.overflow_o, bus.busy_o, bus.tx_data_o);
    end
    commit(32'h80000300, 32'h00400213, 5'd4, 32'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    recv_pkt();
    checks++;
    if (!rx_ok || rx_n !== 4 || rx_w[0] !== 32'hA5002420 || rx_w[1] !== 32'h80000300) begin
      errors++;
      $display("FAIL rstmid_fresh: n=%0d hdr=%h pc=%h, expected 4 a5002420 80000300", rx_n, rx_w[0], rx_w[1]);
    end
  endtask

  initial begin
    bus.update_i = 1'b0;
    bus.pc_i = '0;
    bus.instr_i = '0;
    bus.reg_addr_i = '0;
    bus.reg_data_i = '0;
    bus.reg_we_i = 1'b0;
    bus.mem_read_en_i = 1'b0;
    bus.mem_write_en_i = 1'b0;
    bus.mem_read_addr_i = '0;
    bus.mem_write_addr_i = '0;
    bus.mem_write_data_i = '0;
    bus.store_size_i = '0;
    bus.tx_ready_i = 1'b0;
    test_reset();
    test_regwr();
    test_store();
    test_load_plain();
    test_pc_zero();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
